// File: rtl/pid_sequencer_if.sv
// -----------------------------------------------------------------------------
// pid_sequencer_if
// Bundles the control-loop signals of pid_sequencer:
//   enable       loop run request (0 = stopped)
//   sp_valid     setpoint offer from the UART receive path
//   sp_data      setpoint velocity (unsigned, 9 bits)
//   sp_ready     setpoint accept; transfer when sp_valid && sp_ready
//   pid_in_vel   velocity operand driven to the PID datapath
//   pid_out_vel  PID datapath result (unsigned, 9 bits)
//   duty         commanded duty to the PWM/commutation stage
//   duty_valid   one-cycle pulse marking a new duty value
//   busy         sequencer not idle
//   overrun      sticky: sample tick arrived during a running sequence
// Modports: slave = sequencer side, master = environment side.
// -----------------------------------------------------------------------------
interface pid_sequencer_if;
    logic       enable;
    logic       sp_valid;
    logic [8:0] sp_data;
    logic       sp_ready;
    logic [8:0] pid_in_vel;
    logic [8:0] pid_out_vel;
    logic [8:0] duty;
    logic       duty_valid;
    logic       busy;
    logic       overrun;

    modport slave (
        input  enable, sp_valid, sp_data, pid_out_vel,
        output sp_ready, pid_in_vel, duty, duty_valid, busy, overrun
    );

    modport master (
        output enable, sp_valid, sp_data, pid_out_vel,
        input  sp_ready, pid_in_vel, duty, duty_valid, busy, overrun
    );
endinterface

// File: rtl/pid_sequencer.sv
// -----------------------------------------------------------------------------
// pid_sequencer
// Sequences one PID control update every SAMPLE_DIV clocks:
// IDLE -> LOAD -> WAIT (PID_LAT-1 cycles) -> CAPTURE -> APPLY -> IDLE.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pid_sequencer_if.slave (setpoint handshake, PID operand/result,
//          duty outputs and status flags)
// Build option: define PID_SEQ_SLEW_LIMIT_EN to limit the duty change per
// update to SLEW_STEP; without it APPLY copies the PID result to duty.
// All outputs are driven from registers.
// -----------------------------------------------------------------------------
module pid_sequencer #(
    parameter int SAMPLE_DIV = 1000,
    parameter int PID_LAT    = 2,
    parameter int SLEW_STEP  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pid_sequencer_if.slave        bus
);

    localparam int CNT_W     = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_W    = (PID_LAT > 2) ? $clog2(PID_LAT - 1) : 1;
    localparam int WAIT_LAST = (PID_LAT >= 2) ? (PID_LAT - 2) : 0;

    // Parameter legality, caught at elaboration.
    if (SAMPLE_DIV < PID_LAT + 4) begin : g_bad_sample_div
        $error("pid_sequencer: SAMPLE_DIV must be at least PID_LAT+4");
    end
    if (PID_LAT < 1) begin : g_bad_pid_lat
        $error("pid_sequencer: PID_LAT must be at least 1");
    end
    if (SLEW_STEP < 1 || SLEW_STEP > 511) begin : g_bad_slew_step
        $error("pid_sequencer: SLEW_STEP must be in 1..511");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        APPLY   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                tick_s;
    logic [8:0]          sp_reg_r;
    logic [8:0]          pid_in_vel_r;
    logic [8:0]          cap_reg_r;
    logic [8:0]          duty_r;
    logic                duty_valid_r;
    logic                busy_r;
    logic                overrun_r;
    logic                sp_ready_r;

`ifdef PID_SEQ_SLEW_LIMIT_EN
    // Move duty toward the PID result by at most SLEW_STEP; 10-bit sums
    // keep the comparisons free of wrap-around.
    function automatic logic [8:0] apply_duty(input logic [8:0] cur, input logic [8:0] cap);
        logic [9:0] up_s;
        logic [9:0] cap_up_s;
        logic [8:0] res_s;
        up_s     = {1'b0, cur} + 10'(SLEW_STEP);
        cap_up_s = {1'b0, cap} + 10'(SLEW_STEP);
        if ({1'b0, cap} > up_s) begin
            res_s = (up_s > 10'd511) ? 9'd511 : up_s[8:0];
        end else if (cap_up_s < {1'b0, cur}) begin
            // cap+STEP < cur implies cur > STEP, so this cannot go below 0.
            res_s = cur - 9'(SLEW_STEP);
        end else begin
            res_s = cap;
        end
        return res_s;
    endfunction
`else
    // Unlimited: the PID result becomes the new duty directly.
    function automatic logic [8:0] apply_duty(input logic [8:0] cur, input logic [8:0] cap);
        logic [8:0] unused_cur_s;
        unused_cur_s = cur;
        return cap;
    endfunction
`endif

    assign tick_s = bus.enable && (cnt_r == CNT_W'(SAMPLE_DIV - 1));

    // Sample divider: free-runs while enabled, parked at 0 when stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.enable) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(SAMPLE_DIV - 1)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state logic; dropping enable aborts any sequence back to IDLE.
    always_comb begin
        state_s = state_r;
        if (!bus.enable) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        state_s = LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    // A one-cycle PID latency has no WAIT phase at all.
                    if (PID_LAT == 1) begin
                        state_s = CAPTURE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == WAIT_W'(WAIT_LAST)) begin
                        state_s = CAPTURE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                CAPTURE: state_s = APPLY;
                APPLY:   state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State register and WAIT-phase cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= (state_r == WAIT) ? (wait_cnt_r + WAIT_W'(1)) : {WAIT_W{1'b0}};
        end
    end

    // Datapath and status registers. Each register loads on the edge that
    // enters its state, so the operand appears on the edge after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg_r     <= 9'd0;
            pid_in_vel_r <= 9'd0;
            cap_reg_r    <= 9'd0;
            duty_r       <= 9'd0;
            duty_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            sp_ready_r   <= 1'b1;
        end else begin
            if (bus.sp_valid && sp_ready_r) begin
                sp_reg_r <= bus.sp_data;
            end
            sp_ready_r   <= (state_s != LOAD);
            busy_r       <= (state_s != IDLE);
            duty_valid_r <= (state_s == APPLY);
            if ((state_r == IDLE) && (state_s == LOAD)) begin
                pid_in_vel_r <= sp_reg_r;
            end
            if (state_s == CAPTURE) begin
                cap_reg_r <= bus.pid_out_vel;
            end
            if (!bus.enable) begin
                duty_r    <= 9'd0;
                overrun_r <= 1'b0;
            end else begin
                if (state_s == APPLY) begin
                    duty_r <= apply_duty(duty_r, cap_reg_r);
                end
                // A tick outside IDLE is dropped; only the flag records it.
                if (tick_s && (state_r != IDLE)) begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    assign bus.sp_ready   = sp_ready_r;
    assign bus.pid_in_vel = pid_in_vel_r;
    assign bus.duty       = duty_r;
    assign bus.duty_valid = duty_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_pid_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pid_sequencer
// Directed bench for pid_sequencer (SAMPLE_DIV=16, PID_LAT=2, SLEW_STEP=8).
// The driver pushes each expected duty pulse (value and cycle) into a queue;
// a monitor pops and compares whenever duty_valid is seen.
// -----------------------------------------------------------------------------
module tb_pid_sequencer;

    localparam int SAMPLE_DIV = 16;
    localparam int PID_LAT    = 2;
    localparam int SLEW_STEP  = 8;

    typedef struct {
        logic [8:0] duty;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   start = 0;
    int   tests = 0;
    int   fails = 0;
    int   pid_mode = 0;
    int   model_duty = 0;
    exp_t sb_q[$];

    pid_sequencer_if bus();

    pid_sequencer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .PID_LAT    (PID_LAT),
        .SLEW_STEP  (SLEW_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PID datapath model: in_vel+1, constant 0x100, or constant 0.
    always_comb begin
        if (pid_mode == 1)      bus.pid_out_vel = 9'h100;
        else if (pid_mode == 2) bus.pid_out_vel = 9'h000;
        else                    bus.pid_out_vel = bus.pid_in_vel + 9'd1;
    end

    // Expected duty after one update from duty prev with PID result cap.
    function automatic int exp_duty(input int prev, input int cap);
        int r;
`ifdef PID_SEQ_SLEW_LIMIT_EN
        if (cap > prev + SLEW_STEP)      r = prev + SLEW_STEP;
        else if (cap + SLEW_STEP < prev) r = prev - SLEW_STEP;
        else                             r = cap;
        if (r > 511) r = 511;
        if (r < 0)   r = 0;
`else
        r = cap + 0 * prev;
`endif
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - start);
        end
    endtask

    task automatic push_pulse(input int cap, input int k);
        exp_t e;
        model_duty = exp_duty(model_duty, cap);
        e.duty = model_duty[8:0];
        e.cyc  = start + k;
        sb_q.push_back(e);
    endtask

    // Advance to the negedge following edge k of the current run.
    task automatic goto(input int k);
        while (cyc < start + k) @(negedge clk);
    endtask

    task automatic begin_run();
        start = cyc;
        bus.enable = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.duty_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got duty 0x%0h, expected no pulse (cycle %0d)", bus.duty, cyc - start);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_duty", int'(bus.duty), int'(e.duty));
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.sp_valid = 1'b0;
        bus.sp_data  = 9'd0;
        repeat (3) @(negedge clk);
        check("rst_duty", int'(bus.duty), 0);
        check("rst_duty_valid", int'(bus.duty_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_sp_ready", int'(bus.sp_ready), 1);
        check("rst_pid_in_vel", int'(bus.pid_in_vel), 0);
        rst_n = 1'b1;

        // Setpoint transfer while stopped.
        @(negedge clk);
        bus.sp_valid = 1'b1;
        bus.sp_data  = 9'h161;
        check("idle_sp_ready", int'(bus.sp_ready), 1);
        @(negedge clk);
        bus.sp_valid = 1'b0;

        // Basic sequence, periodic updates, load-cycle hold-off, overrun.
        begin_run();
        push_pulse(9'h162, 19);
        push_pulse(9'h162, 35);
        push_pulse(9'h0A1, 51);
        push_pulse(9'h0A1, 67);
        push_pulse(9'h0A1, 83);
        goto(15);
        check("pre_tick_busy", int'(bus.busy), 0);
        goto(16);
        check("e1_pid_in_vel", int'(bus.pid_in_vel), 9'h161);
        check("load_busy", int'(bus.busy), 1);
        check("load_sp_ready", int'(bus.sp_ready), 0);
        goto(17);
        check("wait_sp_ready", int'(bus.sp_ready), 1);
        goto(20);
        check("after_apply_busy", int'(bus.busy), 0);
        check("after_apply_duty_hold", int'(bus.duty), model_duty >= 0 ? int'(sb_q[0].duty) : 0);

        goto(32);
        bus.sp_valid = 1'b1;
        bus.sp_data  = 9'h0A0;
        check("load2_sp_ready", int'(bus.sp_ready), 0);
        check("load2_old_sp", int'(bus.pid_in_vel), 9'h161);
        goto(34);
        bus.sp_valid = 1'b0;
        goto(48);
        check("new_sp_at_next_load", int'(bus.pid_in_vel), 9'h0A0);

        goto(65);
        check("pre_force_overrun", int'(bus.overrun), 0);
        force dut.tick_s = 1'b1;
        @(posedge clk);
        #1 release dut.tick_s;
        goto(66);
        check("overrun_set", int'(bus.overrun), 1);
        check("overrun_busy", int'(bus.busy), 1);
        goto(80);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Enable dropped during WAIT.
        goto(97);
        bus.enable = 1'b0;
        goto(98);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_duty", int'(bus.duty), 0);
        check("abort_duty_valid", int'(bus.duty_valid), 0);
        check("abort_overrun", int'(bus.overrun), 0);
        check("abort_pid_in_vel", int'(bus.pid_in_vel), 9'h0A0);
        goto(110);
        model_duty = 0;

        // Reset asserted in the middle of APPLY.
        begin_run();
        push_pulse(9'h0A1, 19);
        goto(19);
        check("apply_duty_valid", int'(bus.duty_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_duty", int'(bus.duty), 0);
        check("mid_rst_duty_valid", int'(bus.duty_valid), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_overrun", int'(bus.overrun), 0);
        check("mid_rst_sp_ready", int'(bus.sp_ready), 1);
        check("mid_rst_pid_in_vel", int'(bus.pid_in_vel), 0);
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_duty = 0;

        // PID result 0x100 then 0 (slew-limited when the option is built in).
        pid_mode = 1;
        @(negedge clk);
        begin_run();
        push_pulse(9'h100, 19);
        push_pulse(9'h100, 35);
        push_pulse(9'h100, 51);
        goto(52);
        pid_mode = 2;
        push_pulse(9'h000, 67);
        goto(70);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pid_sequencer.md
PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000: clock cycles per control update; legal range is PID_LAT+4 or more.
REQ-002 Parameter PID_LAT, default 2: cycles the PID datapath needs from an in_vel change to a valid out_vel; legal range is 1 or more.
REQ-003 Parameter SLEW_STEP, default 8: maximum duty change per update when slew limiting is compiled in.
REQ-004 CLK  in  1  system clock; all state changes on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  control loop run; 0 = stopped.
REQ-007 sp_valid  in  1  setpoint offer from the UART receive path.
REQ-008 sp_data  in  9  setpoint velocity, unsigned.
REQ-009 sp_ready  out  1  setpoint accept; a transfer occurs on a cycle with sp_valid=1 and sp_ready=1.
REQ-010 pid_in_vel  out  9  velocity operand driven to the PID datapath.
REQ-011 pid_out_vel  in  9  PID datapath result, unsigned.
REQ-012 duty  out  9  commanded duty to the PWM/commutation stage.
REQ-013 duty_valid  out  1  one-cycle pulse marking a new duty value.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 overrun  out  1  sticky flag: a sample tick arrived while a sequence was still running.

Function
REQ-016 Tick counter: counts 0..SAMPLE_DIV-1 and wraps while enable=1; tick is asserted combinationally when count=SAMPLE_DIV-1; count is held at 0 while enable=0.
REQ-017 Setpoint register sp_reg: loads sp_data on each transfer; sp_ready=0 only in LOAD state, otherwise 1.
REQ-018 FSM states and transitions:
- IDLE: on tick, go to LOAD.
- LOAD: lasts 1 cycle; pid_in_vel <= sp_reg; go to WAIT.
- WAIT: lasts PID_LAT-1 cycles, counted by a wait counter; then go to CAPTURE.
- CAPTURE: cap_reg <= pid_out_vel; go to APPLY.
- APPLY: duty updated and duty_valid=1 for this cycle only; go to IDLE.
REQ-019 Timing, where E1 is the first rising edge after the tick cycle:
- pid_in_vel updates at E1.
- pid_out_vel is sampled at E1+PID_LAT.
- duty and duty_valid update at E1+PID_LAT+1.
REQ-020 Tick while not in IDLE: the tick is dropped, overrun is set, and the running sequence continues unaffected.
REQ-021 Setpoint offered in the same cycle as LOAD: the offer is held off by sp_ready=0 and accepted the next cycle; LOAD uses the old sp_reg.
REQ-022 Setpoint accepted during WAIT, CAPTURE or APPLY: takes effect at the next LOAD only.
REQ-023 enable falling mid-sequence: the next cycle has FSM=IDLE, duty=0, no duty_valid pulse, overrun cleared, and pid_in_vel retained.
REQ-024 All arithmetic is unsigned 9-bit with 10-bit intermediates; results never wrap.

Reset
REQ-025 RST_N=0 asynchronously forces the following, all held until RST_N=1:
- FSM=IDLE and counters=0.
- sp_reg=0, pid_in_vel=0, cap_reg=0, duty=0.
- duty_valid=0, busy=0, overrun=0.
- sp_ready=1.
REQ-026 The first tick occurs SAMPLE_DIV cycles after the first edge with RST_N=1 and enable=1.

Configuration
REQ-027 Macro PID_SEQ_SLEW_LIMIT_EN, when defined, makes APPLY compute duty as follows:
- If cap_reg > duty+SLEW_STEP: duty+SLEW_STEP.
- Else if cap_reg+SLEW_STEP < duty: duty-SLEW_STEP.
- Else: cap_reg.
- The result is clamped to 0..511.
REQ-028 When PID_SEQ_SLEW_LIMIT_EN is undefined, APPLY sets duty=cap_reg and no slew logic is synthesized.

Verification (SAMPLE_DIV=16, PID_LAT=2, SLEW_STEP=8)
REQ-029 Reset then enable=1, sp_data=0x161 transferred, PID model returns in_vel+1 -> pid_in_vel=0x161 at E1, duty=0x162 with duty_valid pulse at E1+3, repeating every 16 cycles.
REQ-030 Force an extra tick during WAIT -> overrun=1 sticky, duty_valid timing of the current sequence unchanged.
REQ-031 sp_valid=1 held across LOAD cycle -> sp_ready=0 in LOAD, transfer the following cycle, new value appears at the next update.
REQ-032 enable dropped during WAIT -> next cycle busy=0, duty=0, no duty_valid; RST_N pulsed mid-APPLY -> all outputs at reset values immediately.
REQ-033 With PID_SEQ_SLEW_LIMIT_EN: duty=0, PID returns 0x100 -> successive duty 8, 16, 24, ...; PID returns 0 from duty=4 -> duty=0, no wrap. Without the macro: duty=0x100 after one update.
